// File: rtl/rn_apb_port.sv
// APB requester port: captures one APB transfer from the requester side, requests the crossbar
// through the arbiter, then replays the transfer toward the decoded completer with a bounded wait.
module rn_apb_port #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   // requester side
   input  logic              s_psel,
   input  logic              s_penable,
   input  logic              s_pwrite,
   input  logic [ADDR_W-1:0] s_paddr,
   input  logic [DATA_W-1:0] s_pwdata,
   output logic [DATA_W-1:0] s_prdata,
   output logic              s_pready,
   output logic              s_pslverr,
   // arbiter handshake
   output logic              rn_valid,
   input  logic              cn_ready,
   // crossbar side
   output logic [2:0]        icn_psel,
   output logic              icn_penable,
   output logic              icn_pwrite,
   output logic [ADDR_W-1:0] icn_paddr,
   output logic [DATA_W-1:0] icn_pwdata,
   input  logic [DATA_W-1:0] icn_prdata,
   input  logic              icn_pready,
   input  logic              icn_pslverr
);

   localparam int unsigned CntW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam bit TimeoutEn          = (TIMEOUT != 0);

   typedef enum logic [2:0] {StIdle, StReq, StSetup, StAccess, StResp} state_e;

   state_e            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              write_q;
   logic [2:0]        sel_q;
   logic [CntW-1:0]   cnt_q;
   logic [2:0]        dec_sel;

   // Completer decode from the top two address bits; all-zero marks a decode error.
   always_comb begin
      dec_sel = 3'b000;
      unique case (s_paddr[ADDR_W-1:ADDR_W-2])
         2'b01:   dec_sel = 3'b001;
         2'b10:   dec_sel = 3'b010;
         2'b11:   dec_sel = 3'b100;
         default: dec_sel = 3'b000;
      endcase
   end

   // Transfer FSM; every output is a flop loaded on the transition into the state that drives it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         addr_q      <= '0;
         wdata_q     <= '0;
         write_q     <= 1'b0;
         sel_q       <= 3'b000;
         cnt_q       <= '0;
         s_prdata    <= '0;
         s_pready    <= 1'b0;
         s_pslverr   <= 1'b0;
         rn_valid    <= 1'b0;
         icn_psel    <= 3'b000;
         icn_penable <= 1'b0;
         icn_pwrite  <= 1'b0;
         icn_paddr   <= '0;
         icn_pwdata  <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               s_pready  <= 1'b0;
               s_pslverr <= 1'b0;
               // Only a setup phase starts a transfer; an access phase left over is ignored.
               if (s_psel && !s_penable) begin
                  addr_q  <= s_paddr;
                  write_q <= s_pwrite;
                  wdata_q <= s_pwdata;
                  sel_q   <= dec_sel;
                  if (dec_sel == 3'b000) begin
                     state_q   <= StResp;
                     s_pready  <= 1'b1;
                     s_pslverr <= 1'b1;
                     s_prdata  <= '0;
                  end else begin
                     state_q  <= StReq;
                     rn_valid <= 1'b1;
                  end
               end
            end
            StReq: begin
               if (cn_ready) begin
                  state_q     <= StSetup;
                  icn_psel    <= sel_q;
                  icn_penable <= 1'b0;
                  icn_paddr   <= addr_q;
                  icn_pwrite  <= write_q;
                  icn_pwdata  <= wdata_q;
               end
            end
            StSetup: begin
               state_q     <= StAccess;
               icn_penable <= 1'b1;
               cnt_q       <= '0;
            end
            StAccess: begin
               cnt_q <= cnt_q + 1'b1;
               // A ready in the last allowed cycle still completes normally.
               if (icn_pready) begin
                  state_q     <= StResp;
                  s_pready    <= 1'b1;
                  s_pslverr   <= icn_pslverr;
                  s_prdata    <= write_q ? '0 : icn_prdata;
                  rn_valid    <= 1'b0;
                  icn_psel    <= 3'b000;
                  icn_penable <= 1'b0;
               end else if (TimeoutEn && (cnt_q == CntMax)) begin
                  state_q     <= StResp;
                  s_pready    <= 1'b1;
                  s_pslverr   <= 1'b1;
                  s_prdata    <= '0;
                  rn_valid    <= 1'b0;
                  icn_psel    <= 3'b000;
                  icn_penable <= 1'b0;
               end
            end
            StResp: begin
               state_q   <= StIdle;
               s_pready  <= 1'b0;
               s_pslverr <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rn_apb_port.sv
// Bench for rn_apb_port: each transfer is described by its grant delay and completer wait, and
// the expected cycle-by-cycle picture is derived from that timeline.
module tb_rn_apb_port;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_psel, s_penable, s_pwrite;
   logic [AW-1:0] s_paddr;
   logic [DW-1:0] s_pwdata, s_prdata;
   logic          s_pready, s_pslverr;
   logic          rn_valid, cn_ready;
   logic [2:0]    icn_psel;
   logic          icn_penable, icn_pwrite;
   logic [AW-1:0] icn_paddr;
   logic [DW-1:0] icn_pwdata, icn_prdata;
   logic          icn_pready, icn_pslverr;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] last_rd;

   rn_apb_port #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_prdata(s_prdata),
      .s_pready(s_pready), .s_pslverr(s_pslverr),
      .rn_valid(rn_valid), .cn_ready(cn_ready),
      .icn_psel(icn_psel), .icn_penable(icn_penable), .icn_pwrite(icn_pwrite),
      .icn_paddr(icn_paddr), .icn_pwdata(icn_pwdata), .icn_prdata(icn_prdata),
      .icn_pready(icn_pready), .icn_pslverr(icn_pslverr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".s_prdata"}, s_prdata, 0);
      chk({tag, ".s_pready"}, s_pready, 0);
      chk({tag, ".s_pslverr"}, s_pslverr, 0);
      chk({tag, ".rn_valid"}, rn_valid, 0);
      chk({tag, ".icn_psel"}, icn_psel, 0);
      chk({tag, ".icn_penable"}, icn_penable, 0);
      chk({tag, ".icn_pwrite"}, icn_pwrite, 0);
      chk({tag, ".icn_paddr"}, icn_paddr, 0);
      chk({tag, ".icn_pwdata"}, icn_pwdata, 0);
   endtask

   // g: REQ cycles before the grant; r: ACCESS wait cycles before icn_pready (r >= TO times out).
   // Cycle 1 is the cycle right after the setup phase was sampled.
   task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd,
                          input int g, input int r, input logic [DW-1:0] rd, input logic err_in,
                          input bit linger);
      logic [1:0]    top;
      bit            dec_err, tmo;
      logic [2:0]    sel;
      int            n_acc, setup_c, acc_c, resp_c;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
      top     = addr[AW-1 -: 2];
      dec_err = (top == 2'd0);
      sel     = dec_err ? 3'b000 : 3'(1 << (top - 1));
      tmo     = (TO != 0) && (r + 1 > int'(TO));
      n_acc   = tmo ? int'(TO) : r + 1;
      setup_c = g + 2;
      acc_c   = g + 3;
      resp_c  = dec_err ? 1 : acc_c + n_acc;
      exp_err = dec_err || tmo || err_in;
      exp_rd  = (dec_err || tmo || wr) ? '0 : rd;

      s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwrite = wr; s_pwdata = wd;
      cn_ready = 1'($urandom_range(0, 1)); icn_pready = 1'b0;
      next_cyc;
      s_penable = 1'b1;
      for (int c = 1; c <= resp_c; c++) begin
         if (!dec_err && c <= g + 1) cn_ready = (c == g + 1);
         else cn_ready = 1'($urandom_range(0, 1));
         icn_pready  = !dec_err && !tmo && (c == acc_c + r);
         icn_prdata  = icn_pready ? rd : DW'($urandom);
         icn_pslverr = icn_pready ? err_in : 1'($urandom_range(0, 1));
         chk("rn_valid", rn_valid, !dec_err && c < resp_c);
         chk("icn_psel", icn_psel, (!dec_err && c >= setup_c && c < resp_c) ? sel : 3'b000);
         chk("icn_penable", icn_penable, !dec_err && c >= acc_c && c < resp_c);
         chk("s_pready", s_pready, c == resp_c);
         if (!dec_err && c == setup_c) begin
            chk("icn_paddr", icn_paddr, addr);
            chk("icn_pwrite", icn_pwrite, wr);
            chk("icn_pwdata", icn_pwdata, wd);
         end
         if (c == resp_c) begin
            chk("s_pslverr", s_pslverr, exp_err);
            chk("s_prdata", s_prdata, exp_rd);
            last_rd = exp_rd;
         end else begin
            chk("s_prdata_hold", s_prdata, last_rd);
         end
         next_cyc;
      end
      // Back in IDLE after the response.
      cn_ready = 1'($urandom_range(0, 1)); icn_pready = 1'b0;
      chk("idle.rn_valid", rn_valid, 0);
      chk("idle.s_pready", s_pready, 0);
      chk("idle.s_prdata", s_prdata, last_rd);
      if (linger) begin
         // Requester still shows the finished access phase: must not restart.
         s_psel = 1'b1; s_penable = 1'b1;
         next_cyc;
         chk("linger.rn_valid", rn_valid, 0);
         chk("linger.s_pready", s_pready, 0);
      end
      s_psel = 1'b0; s_penable = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      s_psel = 1'b0; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = '0; s_pwdata = '0;
      cn_ready = 1'b0; icn_prdata = '0; icn_pready = 1'b0; icn_pslverr = 1'b0;
      last_rd = '0;
      repeat (2) next_cyc;
      chk_all_zero("reset");
      rst = 1'b0;
      next_cyc;

      run_txn(32'h4000_0010, 1'b0, 32'h0, 2, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_txn(32'hC000_0000, 1'b1, 32'h1234_5678, 1, 1, 32'h5555_AAAA, 1'b1, 1'b0);
      run_txn(32'h0000_0004, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1);
      run_txn(32'h8000_0020, 1'b0, 32'h0, 0, 10, 32'h7777_0001, 1'b0, 1'b0);
      run_txn(32'h8000_0024, 1'b0, 32'h0, 0, 3, 32'h0BAD_F00D, 1'b0, 1'b0);
      run_txn(32'h4000_0100, 1'b0, 32'h0, 50, 0, 32'hCAFE_0050, 1'b0, 1'b0);

      // Reset in the middle of ACCESS.
      s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h8000_0100; s_pwrite = 1'b0;
      next_cyc;
      s_penable = 1'b1; cn_ready = 1'b1;
      next_cyc;
      cn_ready = 1'b0;
      next_cyc;
      chk("abort.icn_penable", icn_penable, 1);
      rst = 1'b1; icn_pready = 1'b1; icn_prdata = 32'hFEED_FACE;
      next_cyc;
      chk_all_zero("abort");
      last_rd = '0;
      rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0; icn_pready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         next_cyc;
         chk("abort.s_pready", s_pready, 0);
         chk("abort.rn_valid", rn_valid, 0);
      end
      run_txn(32'hC000_0040, 1'b0, 32'h0, 1, 2, 32'h1357_9BDF, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_txn(AW'($urandom), 1'($urandom_range(0, 1)), DW'($urandom),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), DW'($urandom),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
